// File: rtl/jt12_eg_timer.sv
// Envelope generator timebase: prescaled sample counter plus per-rate step/column decode.
// All outputs are registered; pulses last exactly one clk_en cycle.
module jt12_eg_timer #(
  parameter int unsigned CW  = 15,
  parameter int unsigned DIV = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  input  logic          zero,
  input  logic          hold,
  input  logic          test,
  input  logic [5:0]    rate,
  output logic [CW-1:0] eg_cnt,
  output logic          eg_tick,
  output logic          eg_wrap,
  output logic          eg_step,
  output logic [2:0]    eg_sel
);

  localparam logic [3:0] PreLast = 4'(DIV - 1);

  logic [3:0]    pre_q, pre_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic          step_q, step_d;
  logic [2:0]    sel_q, sel_d;

  logic          q_evt;
  logic          pre_end;
  logic          adv;
  logic [CW-1:0] n;
  logic [3:0]    shift;
  logic [CW-1:0] mask;
  logic          step_n;
  logic [2:0]    sel_n;

  always_comb begin
    q_evt   = zero & clk_en & ~hold;
    pre_end = (pre_q == PreLast);
    adv     = q_evt & (test | pre_end);

    pre_d = pre_q;
    if (q_evt) begin
      pre_d = (test | pre_end) ? 4'd0 : pre_q + 4'd1;
    end

    n = cnt_q + CW'(1);

    // Rates 48..63 behave like shift 0: step on every advance.
    shift = (rate[5:2] <= 4'd11) ? 4'd11 - rate[5:2] : 4'd0;
    mask  = (CW'(1) << shift) - CW'(1);
    sel_n = 3'(n >> shift);
    if (rate[5:1] == 5'd0) begin
      step_n = 1'b0;
    end else begin
      step_n = ((n & mask) == '0);
    end

    cnt_d  = adv ? n : cnt_q;
    tick_d = adv;
    wrap_d = adv & (&cnt_q);
    step_d = adv & step_n;
    sel_d  = (adv & step_n) ? sel_n : sel_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= 4'd0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      step_q <= 1'b0;
      sel_q  <= 3'd0;
    end else if (clk_en) begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
      step_q <= step_d;
      sel_q  <= sel_d;
    end
  end

  assign eg_cnt  = cnt_q;
  assign eg_tick = tick_q;
  assign eg_wrap = wrap_q;
  assign eg_step = step_q;
  assign eg_sel  = sel_q;

endmodule

// File: tb/tb_jt12_eg_timer.sv
// Directed bench for jt12_eg_timer (CW=15, DIV=3): per-cycle vector table plus
// multi-cycle sequences for prescaler spacing, hold, test mode, reset, wrap and rate decode.
module tb_jt12_eg_timer;

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic        zero;
  logic        hold;
  logic        test;
  logic [5:0]  rate;
  logic [14:0] eg_cnt;
  logic        eg_tick;
  logic        eg_wrap;
  logic        eg_step;
  logic [2:0]  eg_sel;

  int n_vec = 0;
  int n_err = 0;

  jt12_eg_timer #(.CW(15), .DIV(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_en  (clk_en),
    .zero    (zero),
    .hold    (hold),
    .test    (test),
    .rate    (rate),
    .eg_cnt  (eg_cnt),
    .eg_tick (eg_tick),
    .eg_wrap (eg_wrap),
    .eg_step (eg_step),
    .eg_sel  (eg_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en, z, h, t;
    logic [5:0]  rate;
    logic [14:0] cnt;
    logic        tick, wrap, step;
    logic [2:0]  sel;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic en, input logic z, input logic h, input logic t,
                     input logic [5:0] r, input logic [14:0] c, input logic tk,
                     input logic wr, input logic st, input logic [2:0] sl);
    vec_t v;
    v.en = en; v.z = z; v.h = h; v.t = t; v.rate = r;
    v.cnt = c; v.tick = tk; v.wrap = wr; v.step = st; v.sel = sl;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int idx, input logic [14:0] c,
                         input logic tk, input logic wr, input logic st, input logic [2:0] sl);
    chk({nm, ".cnt"}, idx, 32'(eg_cnt), 32'(c));
    chk({nm, ".tick"}, idx, 32'(eg_tick), 32'(tk));
    chk({nm, ".wrap"}, idx, 32'(eg_wrap), 32'(wr));
    chk({nm, ".step"}, idx, 32'(eg_step), 32'(st));
    chk({nm, ".sel"}, idx, 32'(eg_sel), 32'(sl));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called just after a sampling point, so the reset pulse sits mid-cycle.
  task automatic do_reset();
    clk_en = 1'b1; zero = 1'b0; hold = 1'b0; test = 1'b0; rate = 6'd0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  int ticks;

  initial begin
    rst_n = 1'b0; clk_en = 1'b0; zero = 1'b0; hold = 1'b0; test = 1'b0; rate = 6'd0;
    #1;
    chk_all("reset", 0, 15'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    #10;
    rst_n = 1'b1;
    clk_en = 1'b1;
    cyc();

    // en z h t rate | cnt tick wrap step sel
    add(1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  15'd0,  1'b0, 1'b0, 1'b0, 3'd0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 6'd50, 15'd0,  1'b0, 1'b0, 1'b0, 3'd0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 6'd50, 15'd0,  1'b0, 1'b0, 1'b0, 3'd0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 6'd50, 15'd1,  1'b1, 1'b0, 1'b1, 3'd1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 6'd50, 15'd1,  1'b0, 1'b0, 1'b0, 3'd1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 6'd50, 15'd1,  1'b0, 1'b0, 1'b0, 3'd1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 6'd50, 15'd1,  1'b0, 1'b0, 1'b0, 3'd1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 6'd50, 15'd1,  1'b0, 1'b0, 1'b0, 3'd1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 6'd50, 15'd1,  1'b0, 1'b0, 1'b0, 3'd1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 6'd50, 15'd1,  1'b0, 1'b0, 1'b0, 3'd1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 6'd50, 15'd1,  1'b0, 1'b0, 1'b0, 3'd1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 6'd50, 15'd2,  1'b1, 1'b0, 1'b1, 3'd2);
    add(1'b1, 1'b1, 1'b0, 1'b0, 6'd50, 15'd2,  1'b0, 1'b0, 1'b0, 3'd2);
    add(1'b1, 1'b1, 1'b0, 1'b1, 6'd50, 15'd3,  1'b1, 1'b0, 1'b1, 3'd3);
    add(1'b1, 1'b1, 1'b0, 1'b1, 6'd0,  15'd4,  1'b1, 1'b0, 1'b0, 3'd3);
    add(1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  15'd4,  1'b0, 1'b0, 1'b0, 3'd3);
    add(1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  15'd4,  1'b0, 1'b0, 1'b0, 3'd3);
    add(1'b1, 1'b1, 1'b0, 1'b0, 6'd20, 15'd5,  1'b1, 1'b0, 1'b0, 3'd3);
    add(1'b1, 1'b1, 1'b0, 1'b1, 6'd2,  15'd6,  1'b1, 1'b0, 1'b0, 3'd3);
    add(1'b1, 1'b1, 1'b0, 1'b1, 6'd47, 15'd7,  1'b1, 1'b0, 1'b1, 3'd7);
    add(1'b1, 1'b1, 1'b0, 1'b1, 6'd44, 15'd8,  1'b1, 1'b0, 1'b1, 3'd0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 6'd40, 15'd9,  1'b1, 1'b0, 1'b0, 3'd0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 6'd40, 15'd10, 1'b1, 1'b0, 1'b1, 3'd5);
    add(1'b1, 1'b1, 1'b0, 1'b1, 6'd40, 15'd11, 1'b1, 1'b0, 1'b0, 3'd5);
    add(1'b0, 1'b1, 1'b0, 1'b1, 6'd40, 15'd11, 1'b1, 1'b0, 1'b0, 3'd5);
    add(1'b1, 1'b0, 1'b0, 1'b0, 6'd40, 15'd11, 1'b0, 1'b0, 1'b0, 3'd5);

    foreach (tbl[i]) begin
      clk_en = tbl[i].en; zero = tbl[i].z; hold = tbl[i].h; test = tbl[i].t;
      rate = tbl[i].rate;
      cyc();
      chk_all("vec", i, tbl[i].cnt, tbl[i].tick, tbl[i].wrap, tbl[i].step, tbl[i].sel);
    end

    // Nine strobes 24 clocks apart: advance on strobes 3, 6, 9, one-cycle ticks.
    do_reset();
    ticks = 0;
    for (int k = 1; k <= 9; k++) begin
      zero = 1'b1;
      cyc();
      chk("div3.cnt", k, 32'(eg_cnt), 32'(k / 3));
      chk("div3.tick", k, 32'(eg_tick), 32'((k % 3) == 0));
      if (eg_tick) ticks++;
      zero = 1'b0;
      for (int j = 0; j < 23; j++) begin
        cyc();
        if (eg_tick) ticks++;
      end
    end
    chk("div3.ticks", 0, 32'(ticks), 32'd3);

    // Hold with pre=1: no advance during hold, advance on 2nd q after release.
    do_reset();
    zero = 1'b1;
    cyc();
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("hold.cnt", k, 32'(eg_cnt), 32'd0);
    end
    hold = 1'b0;
    cyc();
    chk("hold.rel1", 0, 32'(eg_cnt), 32'd0);
    cyc();
    chk("hold.rel2", 0, 32'(eg_cnt), 32'd1);
    chk("hold.tick", 0, 32'(eg_tick), 32'd1);

    // Test mode, then mid-cycle reset discarding the prescaler phase.
    do_reset();
    test = 1'b1; zero = 1'b1;
    repeat (4) cyc();
    chk("test.cnt", 0, 32'(eg_cnt), 32'd4);
    test = 1'b0;
    cyc();
    chk("test.pre1", 0, 32'(eg_cnt), 32'd4);
    rst_n = 1'b0;
    #1;
    chk_all("arst", 0, 15'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    #2;
    rst_n = 1'b1;
    zero = 1'b0;
    cyc();
    chk_all("arst.rel", 0, 15'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    zero = 1'b1;
    cyc();
    chk("arst.q1", 0, 32'(eg_cnt), 32'd0);
    cyc();
    chk("arst.q2", 0, 32'(eg_cnt), 32'd0);
    cyc();
    chk("arst.q3", 0, 32'(eg_cnt), 32'd1);

    // Wrap from 0x7FFF to 0.
    do_reset();
    test = 1'b1; zero = 1'b1;
    repeat (32767) cyc();
    chk("wrap.pre_cnt", 0, 32'(eg_cnt), 32'h7fff);
    chk("wrap.pre_wrap", 0, 32'(eg_wrap), 32'd0);
    cyc();
    chk_all("wrap", 0, 15'd0, 1'b1, 1'b1, 1'b0, 3'd0);
    zero = 1'b0;
    cyc();
    chk("wrap.clr", 0, 32'(eg_wrap), 32'd0);
    chk("wrap.tclr", 0, 32'(eg_tick), 32'd0);

    // rate=20: step only at multiples of 64, sel = n[8:6].
    do_reset();
    test = 1'b1; zero = 1'b1; rate = 6'd20;
    for (int n = 1; n <= 128; n++) begin
      cyc();
      chk("r20.step", n, 32'(eg_step), 32'((n % 64) == 0));
      if (n == 64) chk("r20.sel64", n, 32'(eg_sel), 32'd1);
      if (n == 128) chk("r20.sel128", n, 32'(eg_sel), 32'd2);
    end

    // rate=0: never steps; rate=50: steps every advance, sel = n[2:0].
    do_reset();
    test = 1'b1; zero = 1'b1; rate = 6'd0;
    for (int n = 1; n <= 64; n++) begin
      cyc();
      chk("r0.step", n, 32'(eg_step), 32'd0);
      chk("r0.sel", n, 32'(eg_sel), 32'd0);
    end
    rate = 6'd50;
    for (int n = 65; n <= 72; n++) begin
      cyc();
      chk("r50.step", n, 32'(eg_step), 32'd1);
      chk("r50.sel", n, 32'(eg_sel), 32'(n % 8));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
